// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the five-stage pipeline. Drives the
// stall/flush pair of every inter-stage register plus the PC hold, resolving
// data-memory freeze, branch-mispredict recovery, multi-cycle mul/div
// occupancy, load-use hazards and rename free-list exhaustion. Also keeps a
// saturating count of PC-stalled cycles.
module pipeline_hazard_ctrl #(
    parameter int PREG_WIDTH     = 6,
    parameter int MD_LATENCY     = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PREG_WIDTH-1:0]  dec_rs_addr,
    input  logic [PREG_WIDTH-1:0]  dec_rt_addr,
    input  logic                   dec_rs_used,
    input  logic                   dec_rt_used,
    input  logic                   exec_mem_read,
    input  logic [PREG_WIDTH-1:0]  exec_wb_addr,
    input  logic                   exec_md_valid,
    input  logic                   exec_mispredict,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    input  logic                   free_list_empty,
    input  logic                   perf_clear,
    output logic                   pc_stall,
    output logic                   f2d_stall,
    output logic                   f2d_flush,
    output logic                   d2e_stall,
    output logic                   d2e_flush,
    output logic                   e2m_stall,
    output logic                   e2m_flush,
    output logic                   m2w_stall,
    output logic                   m2w_flush,
    output logic [1:0]             state_out,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MD_BUSY = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    // The down-counter must hold the larger of the two reload values.
    localparam int CNT_MAX = ((MD_LATENCY - 2) > (RECOVER_CYCLES - 1)) ?
                             (MD_LATENCY - 2) : (RECOVER_CYCLES - 1);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MD_RELOAD  = CNT_W'(MD_LATENCY - 2);
    localparam logic [CNT_W-1:0] REC_RELOAD = CNT_W'(RECOVER_CYCLES - 1);

    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_md_done;
    logic [COUNT_WIDTH-1:0] r_stall_count;

    logic [1:0]             w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_md_done_nxt;
    logic                   w_freeze;
    logic                   w_load_use;
    logic                   w_pc_stall;
    logic                   w_f2d_stall;
    logic                   w_f2d_flush;
    logic                   w_d2e_stall;
    logic                   w_d2e_flush;
    logic                   w_e2m_stall;
    logic                   w_e2m_flush;
    logic                   w_m2w_flush;

    assign w_freeze   = mem_req & ~mem_ready;
    assign w_load_use = exec_mem_read &
                        ((dec_rs_used & (dec_rs_addr == exec_wb_addr)) |
                         (dec_rt_used & (dec_rt_addr == exec_wb_addr)));

    // Priority resolution of hazards into stage controls and next FSM state.
    always_comb begin
        w_pc_stall    = 1'b0;
        w_f2d_stall   = 1'b0;
        w_f2d_flush   = 1'b0;
        w_d2e_stall   = 1'b0;
        w_d2e_flush   = 1'b0;
        w_e2m_stall   = 1'b0;
        w_e2m_flush   = 1'b0;
        w_m2w_flush   = 1'b0;
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_md_done_nxt = r_md_done;
        if (rst) begin
            // Drain the whole pipeline with bubbles while in reset.
            w_f2d_flush = 1'b1;
            w_d2e_flush = 1'b1;
            w_e2m_flush = 1'b1;
            w_m2w_flush = 1'b1;
        end else if (w_freeze) begin
            // Memory wait: everything upstream of writeback holds; the
            // sequencer itself freezes so pending work resumes afterwards.
            w_pc_stall  = 1'b1;
            w_f2d_stall = 1'b1;
            w_d2e_stall = 1'b1;
            w_e2m_stall = 1'b1;
            w_m2w_flush = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_md_done_nxt = 1'b0;
                    if (exec_mispredict) begin
                        // PC loads the redirect target, so it is not held.
                        w_f2d_flush = 1'b1;
                        w_d2e_flush = 1'b1;
                        w_state_nxt = ST_RECOVER;
                        w_cnt_nxt   = REC_RELOAD;
                    end else if (exec_md_valid && !r_md_done) begin
                        w_pc_stall  = 1'b1;
                        w_f2d_stall = 1'b1;
                        w_d2e_stall = 1'b1;
                        w_e2m_flush = 1'b1;
                        w_state_nxt = ST_MD_BUSY;
                        w_cnt_nxt   = MD_RELOAD;
                    end else if (w_load_use || free_list_empty) begin
                        w_pc_stall  = 1'b1;
                        w_f2d_stall = 1'b1;
                        w_d2e_flush = 1'b1;
                    end
                end
                ST_MD_BUSY: begin
                    w_pc_stall  = 1'b1;
                    w_f2d_stall = 1'b1;
                    w_d2e_stall = 1'b1;
                    w_e2m_flush = 1'b1;
                    if (r_cnt == '0) begin
                        // md_done stops the still-resident mul/div from
                        // retriggering on the release cycle.
                        w_state_nxt   = ST_RUN;
                        w_md_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                ST_RECOVER: begin
                    w_pc_stall  = 1'b1;
                    w_f2d_stall = 1'b1;
                    w_d2e_flush = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // FSM, down-counter and md_done flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_md_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_md_done <= w_md_done_nxt;
        end
    end

    // Saturating count of PC-stalled cycles; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || perf_clear) begin
            r_stall_count <= '0;
        end else if (w_pc_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign pc_stall    = w_pc_stall;
    assign f2d_stall   = w_f2d_stall;
    assign f2d_flush   = w_f2d_flush;
    assign d2e_stall   = w_d2e_stall;
    assign d2e_flush   = w_d2e_flush;
    assign e2m_stall   = w_e2m_stall;
    assign e2m_flush   = w_e2m_flush;
    assign m2w_stall   = 1'b0;
    assign m2w_flush   = w_m2w_flush;
    assign state_out   = rst ? ST_RUN : r_state;
    assign stall_count = r_stall_count;

endmodule
